dand_bus_arbiter: RTL and testbench

DAND_BUS_ARBITER -- requirements
Module: dand_bus_arbiter

---
 rtl/dand_bus_arbiter_if.sv | 37 +++
 rtl/dand_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_dand_bus_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dand_bus_arbiter_if.sv
// dand_bus_arbiter_if -- command/response link between a requester and a responder.
//
// One instance carries a single cmd/rsp channel. The requester side uses the `master`
// modport and the responder side uses the `slave` modport. The arbiter takes two
// requester links on `slave` and drives the shared downstream link on `master`.
//
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr             byte address (ADDR_W)
//   cmd_wdata/cmd_wstrb  write data (DATA_W) and byte enables (DATA_W/8)
//   rsp_valid            one-cycle response pulse (no back-pressure)
//   rsp_rdata/rsp_error  read data and error flag
interface dand_bus_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_W-1:0]     cmd_addr;
   logic [DATA_W-1:0]     cmd_wdata;
   logic [DATA_W/8-1:0]   cmd_wstrb;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_error;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/dand_bus_arbiter.sv
// dand_bus_arbiter -- two-requester round-robin arbiter onto one downstream cmd/rsp link.
//
// At most one transaction is outstanding. In idle a requester is granted (round-robin on
// contention, m0 wins the first contention after reset), its command is latched and
// presented downstream, and the downstream response is forwarded to the granted requester
// in the same cycle it arrives.
//
// Optional feature: define ARB_TIMEOUT_EN to abandon a response wait after TIMEOUT cycles
// with an error response (rdata = 0). Without it the response wait is unbounded.
//
// Ports:
//   io_axiClk        clock, all state on the rising edge
//   io_asyncResetn   asynchronous active-low reset
//   m0, m1           requester links (slave modport)
//   s                downstream link (master modport)
//   grant_id         index of the current/last granted requester
//   busy             high while a transaction is in flight
module dand_bus_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               io_axiClk,
   input  logic               io_asyncResetn,
   dand_bus_arbiter_if.slave  m0,
   dand_bus_arbiter_if.slave  m1,
   dand_bus_arbiter_if.master s,
   output logic               grant_id,
   output logic               busy
);

   localparam int unsigned StrbW = DATA_W / 8;

   typedef enum logic [1:0] {StIdle, StCmd, StRsp} state_e;

   state_e              state_q;
   logic                rr_last_q;
   logic                grant_q;
   logic                s_write_q;
   logic [ADDR_W-1:0]   s_addr_q;
   logic [DATA_W-1:0]   s_wdata_q;
   logic [StrbW-1:0]    s_wstrb_q;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW =
      ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CntW-1:0]     tmo_cnt_q;
`endif

   logic                idle;
   logic                any_req;
   logic                pick;
   logic                rsp_fire;
   logic                tmo_fire;
   logic                done;
   logic [DATA_W-1:0]   rdata_fwd;
   logic                error_fwd;

   assign idle    = (state_q == StIdle);
   assign any_req = m0.cmd_valid | m1.cmd_valid;
   // Contention goes to whoever was not served last; otherwise the lone requester wins.
   assign pick    = (m0.cmd_valid & m1.cmd_valid) ? ~rr_last_q : m1.cmd_valid;

   // A response can complete either straight out of CMD (same cycle as cmd_ready) or in RSP.
   assign rsp_fire = s.rsp_valid &
                     (((state_q == StCmd) & s.cmd_ready) | (state_q == StRsp));

`ifdef ARB_TIMEOUT_EN
   assign tmo_fire = (state_q == StRsp) & ~s.rsp_valid &
                     (tmo_cnt_q == CntW'(TIMEOUT - 1));
`else
   assign tmo_fire = 1'b0;
`endif

   assign done      = rsp_fire | tmo_fire;
   assign rdata_fwd = rsp_fire ? s.rsp_rdata : '0;
   assign error_fwd = rsp_fire ? s.rsp_error : tmo_fire;

   // Ready is combinational in the grant cycle; gated by reset so it is low while held.
   assign m0.cmd_ready = io_asyncResetn & idle & any_req & ~pick;
   assign m1.cmd_ready = io_asyncResetn & idle & any_req & pick;

   assign m0.rsp_valid = done & ~grant_q;
   assign m1.rsp_valid = done & grant_q;
   assign m0.rsp_rdata = m0.rsp_valid ? rdata_fwd : '0;
   assign m1.rsp_rdata = m1.rsp_valid ? rdata_fwd : '0;
   assign m0.rsp_error = m0.rsp_valid & error_fwd;
   assign m1.rsp_error = m1.rsp_valid & error_fwd;

   assign s.cmd_valid = (state_q == StCmd);
   assign s.cmd_write = s_write_q;
   assign s.cmd_addr  = s_addr_q;
   assign s.cmd_wdata = s_wdata_q;
   assign s.cmd_wstrb = s_wstrb_q;

   assign grant_id = grant_q;
   assign busy     = ~idle;

   always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         state_q   <= StIdle;
         rr_last_q <= 1'b1;
         grant_q   <= 1'b0;
         s_write_q <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_wstrb_q <= '0;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt_q <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  state_q   <= StCmd;
                  grant_q   <= pick;
                  s_write_q <= pick ? m1.cmd_write : m0.cmd_write;
                  s_addr_q  <= pick ? m1.cmd_addr  : m0.cmd_addr;
                  s_wdata_q <= pick ? m1.cmd_wdata : m0.cmd_wdata;
                  s_wstrb_q <= pick ? m1.cmd_wstrb : m0.cmd_wstrb;
               end
            end
            StCmd: begin
               if (s.cmd_ready) begin
                  if (s.rsp_valid) begin
                     state_q   <= StIdle;
                     rr_last_q <= grant_q;
                  end else begin
                     state_q   <= StRsp;
`ifdef ARB_TIMEOUT_EN
                     tmo_cnt_q <= '0;
`endif
                  end
               end
            end
            StRsp: begin
               if (done) begin
                  state_q   <= StIdle;
                  rr_last_q <= grant_q;
               end
`ifdef ARB_TIMEOUT_EN
               else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dand_bus_arbiter.sv
// tb_dand_bus_arbiter -- directed scenarios plus a randomized run against a
// transaction-level reference model of the arbiter.
module tb_dand_bus_arbiter;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = DW / 8;
   localparam int unsigned TMO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic grant_id;
   logic busy;
   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   dand_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
   dand_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
   dand_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

   dand_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .io_axiClk      (clk),
      .io_asyncResetn (rst_n),
      .m0             (m0_if),
      .m1             (m1_if),
      .s              (s_if),
      .grant_id       (grant_id),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // {m0 ready, m1 ready, m0 rsp_valid, m1 rsp_valid, s cmd_valid, busy, grant_id}
   function automatic logic [6:0] ctl();
      return {m0_if.cmd_ready, m1_if.cmd_ready, m0_if.rsp_valid, m1_if.rsp_valid,
              s_if.cmd_valid, busy, grant_id};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_if.cmd_valid = 1'b0; m0_if.cmd_write = 1'b0; m0_if.cmd_addr = '0;
      m0_if.cmd_wdata = '0;   m0_if.cmd_wstrb = '0;
      m1_if.cmd_valid = 1'b0; m1_if.cmd_write = 1'b0; m1_if.cmd_addr = '0;
      m1_if.cmd_wdata = '0;   m1_if.cmd_wstrb = '0;
      s_if.cmd_ready = 1'b0;  s_if.rsp_valid = 1'b0;  s_if.rsp_rdata = '0;
      s_if.rsp_error = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      m0_if.cmd_valid = 1'b1; m1_if.cmd_valid = 1'b1;
      s_if.cmd_ready = 1'b1;  s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'hFFFF_FFFF;
      #1;
      n_chk++;
      if (ctl() !== 7'b0) begin
         n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl(), 7'b0);
      end
      n_chk++;
      if ({s_if.cmd_write, s_if.cmd_addr, s_if.cmd_wdata, s_if.cmd_wstrb} !== '0) begin
         n_fail++; $display("FAIL reset_payload: got %h want 0",
                            {s_if.cmd_write, s_if.cmd_addr, s_if.cmd_wdata, s_if.cmd_wstrb});
      end
      n_chk++;
      if ({m0_if.rsp_rdata, m1_if.rsp_rdata, m0_if.rsp_error, m1_if.rsp_error} !== '0) begin
         n_fail++; $display("FAIL reset_rsp_data: got nonzero want 0");
      end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (ctl() !== 7'b0) begin
         n_fail++; $display("FAIL reset_release: got %b want %b", ctl(), 7'b0);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      m0_if.cmd_valid = 1'b1; m0_if.cmd_write = 1'b0; m0_if.cmd_addr = 32'h1000;
      #1;
      n_chk++;
      if (ctl() !== 7'b1000000) begin
         n_fail++; $display("FAIL rd_grant: got %b want %b", ctl(), 7'b1000000);
      end
      tick();
      m0_if.cmd_valid = 1'b0; s_if.cmd_ready = 1'b1;
      #1;
      n_chk++;
      if (ctl() !== 7'b0000110) begin
         n_fail++; $display("FAIL rd_cmd: got %b want %b", ctl(), 7'b0000110);
      end
      n_chk++;
      if ({s_if.cmd_write, s_if.cmd_addr} !== {1'b0, 32'h1000}) begin
         n_fail++; $display("FAIL rd_cmd_addr: got %b/%h want 0/00001000",
                            s_if.cmd_write, s_if.cmd_addr);
      end
      tick();
      s_if.cmd_ready = 1'b0; s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'hDEAD_BEEF;
      #1;
      n_chk++;
      if (ctl() !== 7'b0010010) begin
         n_fail++; $display("FAIL rd_rsp: got %b want %b", ctl(), 7'b0010010);
      end
      n_chk++;
      if ({m0_if.rsp_rdata, m0_if.rsp_error, m1_if.rsp_rdata, m1_if.rsp_error} !==
          {32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0}) begin
         n_fail++; $display("FAIL rd_rsp_data: got m0 %h/%b m1 %h/%b want deadbeef/0 0/0",
                            m0_if.rsp_rdata, m0_if.rsp_error, m1_if.rsp_rdata, m1_if.rsp_error);
      end
      tick();
      s_if.rsp_valid = 1'b0; s_if.rsp_rdata = '0;
      #1;
      n_chk++;
      if (ctl() !== 7'b0) begin
         n_fail++; $display("FAIL rd_done: got %b want %b", ctl(), 7'b0);
      end
   endtask

   task automatic test_round_robin();
      logic prev;
      logic [6:0] want;
      int e;
      do_reset();
      prev = 1'b0;
      m0_if.cmd_valid = 1'b1; m0_if.cmd_addr = 32'hA0;
      m1_if.cmd_valid = 1'b1; m1_if.cmd_addr = 32'hB0;
      s_if.cmd_ready = 1'b1;  s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h1234;
      for (int k = 0; k < 4; k++) begin
         e = k % 2;
         #1;
         want = {e == 0, e == 1, 1'b0, 1'b0, 1'b0, 1'b0, prev};
         n_chk++;
         if (ctl() !== want) begin
            n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, ctl(), want);
         end
         tick();
         want = {1'b0, 1'b0, e == 0, e == 1, 1'b1, 1'b1, e[0]};
         n_chk++;
         if (ctl() !== want) begin
            n_fail++; $display("FAIL rr_cmd%0d: got %b want %b", k, ctl(), want);
         end
         n_chk++;
         if (s_if.cmd_addr !== ((e == 1) ? 32'hB0 : 32'hA0)) begin
            n_fail++; $display("FAIL rr_addr%0d: got %h want %h", k, s_if.cmd_addr,
                               (e == 1) ? 32'hB0 : 32'hA0);
         end
         prev = e[0];
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_cmd_stall();
      int rdy_cnt;
      do_reset();
      rdy_cnt = 0;
      m1_if.cmd_valid = 1'b1; m1_if.cmd_write = 1'b1; m1_if.cmd_addr = 32'h2000;
      m1_if.cmd_wdata = 32'h1234_5678; m1_if.cmd_wstrb = 4'hF;
      #1;
      n_chk++;
      if (ctl() !== 7'b0100000) begin
         n_fail++; $display("FAIL stall_grant: got %b want %b", ctl(), 7'b0100000);
      end
      if (m1_if.cmd_ready) rdy_cnt++;
      for (int k = 0; k < 6; k++) begin
         tick();
         s_if.cmd_ready = (k == 5);
         #1;
         if (m1_if.cmd_ready) rdy_cnt++;
         n_chk++;
         if (ctl() !== 7'b0000111) begin
            n_fail++; $display("FAIL stall_ctl%0d: got %b want %b", k, ctl(), 7'b0000111);
         end
         n_chk++;
         if ({s_if.cmd_write, s_if.cmd_addr, s_if.cmd_wdata, s_if.cmd_wstrb} !==
             {1'b1, 32'h2000, 32'h1234_5678, 4'hF}) begin
            n_fail++; $display("FAIL stall_payload%0d: got %b %h %h %h want 1 2000 12345678 f",
                               k, s_if.cmd_write, s_if.cmd_addr, s_if.cmd_wdata, s_if.cmd_wstrb);
         end
      end
      tick();
      m1_if.cmd_valid = 1'b0; s_if.cmd_ready = 1'b0;
      s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h0000_00AA;
      #1;
      n_chk++;
      if (ctl() !== 7'b0001011) begin
         n_fail++; $display("FAIL stall_rsp: got %b want %b", ctl(), 7'b0001011);
      end
      n_chk++;
      if (rdy_cnt != 1) begin
         n_fail++; $display("FAIL stall_ready_count: got %0d want 1", rdy_cnt);
      end
      tick();
      idle_inputs();
      #1;
      n_chk++;
      if (ctl() !== 7'b0000001) begin
         n_fail++; $display("FAIL stall_done: got %b want %b", ctl(), 7'b0000001);
      end
   endtask

   task automatic test_rsp_with_cmd();
      do_reset();
      m0_if.cmd_valid = 1'b1; m0_if.cmd_addr = 32'h44;
      #1;
      tick();
      m0_if.cmd_valid = 1'b0;
      s_if.cmd_ready = 1'b1; s_if.rsp_valid = 1'b1; s_if.rsp_error = 1'b1;
      s_if.rsp_rdata = 32'h0BAD_0BAD;
      #1;
      n_chk++;
      if (ctl() !== 7'b0010110) begin
         n_fail++; $display("FAIL fast_rsp: got %b want %b", ctl(), 7'b0010110);
      end
      n_chk++;
      if ({m0_if.rsp_rdata, m0_if.rsp_error} !== {32'h0BAD_0BAD, 1'b1}) begin
         n_fail++; $display("FAIL fast_rsp_data: got %h/%b want 0bad0bad/1",
                            m0_if.rsp_rdata, m0_if.rsp_error);
      end
      tick();
      idle_inputs();
      #1;
      n_chk++;
      if (ctl() !== 7'b0) begin
         n_fail++; $display("FAIL fast_idle: got %b want %b", ctl(), 7'b0);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      m1_if.cmd_valid = 1'b1; m1_if.cmd_addr = 32'h77;
      #1;
      tick();
      m1_if.cmd_valid = 1'b0; s_if.cmd_ready = 1'b1;
      tick();
      s_if.cmd_ready = 1'b0;
      #1;
      n_chk++;
      if (ctl() !== 7'b0000011) begin
         n_fail++; $display("FAIL mid_in_rsp: got %b want %b", ctl(), 7'b0000011);
      end
      rst_n = 1'b0;
      m0_if.cmd_valid = 1'b1;
      #1;
      n_chk++;
      if ({ctl(), s_if.cmd_addr} !== '0) begin
         n_fail++; $display("FAIL mid_reset: got %b/%h want 0/0", ctl(), s_if.cmd_addr);
      end
      tick();
      rst_n = 1'b1;
      m0_if.cmd_valid = 1'b0;
      s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h5555_5555;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++;
         if ({m0_if.rsp_valid, m1_if.rsp_valid, busy} !== 3'b000) begin
            n_fail++; $display("FAIL mid_late_rsp%0d: got %b want 000", k,
                               {m0_if.rsp_valid, m1_if.rsp_valid, busy});
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      m0_if.cmd_valid = 1'b1;
      #1;
      tick();
      m0_if.cmd_valid = 1'b0; s_if.cmd_ready = 1'b1;
      tick();
      s_if.cmd_ready = 1'b0; s_if.rsp_rdata = 32'hFFFF_FFFF;
`ifdef ARB_TIMEOUT_EN
      for (int k = 1; k <= int'(TMO); k++) begin
         #1;
         n_chk++;
         if (m0_if.rsp_valid !== (k == int'(TMO))) begin
            n_fail++; $display("FAIL tmo_pulse%0d: got %b want %b", k, m0_if.rsp_valid,
                               k == int'(TMO));
         end
         if (k == int'(TMO)) begin
            n_chk++;
            if ({m0_if.rsp_rdata, m0_if.rsp_error} !== {32'h0, 1'b1}) begin
               n_fail++; $display("FAIL tmo_data: got %h/%b want 0/1",
                                  m0_if.rsp_rdata, m0_if.rsp_error);
            end
         end
         tick();
      end
      #1;
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL tmo_idle: got busy %b want 0", busy);
      end
`else
      for (int k = 0; k < 300; k++) begin
         #1;
         n_chk++;
         if ({m0_if.rsp_valid, busy} !== 2'b01) begin
            n_fail++; $display("FAIL notmo_wait%0d: got %b want 01", k, {m0_if.rsp_valid, busy});
         end
         tick();
      end
`endif
      idle_inputs();
   endtask

   task automatic test_random();
      int owner, win, wait_c;
      bit in_cmd, last, fire, tmo;
      logic gid;
      logic v[2], wr[2];
      logic [AW-1:0] ad[2];
      logic [DW-1:0] wd[2];
      logic [SW-1:0] ws[2];
      bit acc[2];
      logic l_wr;
      logic [AW-1:0] l_ad;
      logic [DW-1:0] l_wd, e_data;
      logic [SW-1:0] l_ws;
      logic [1:0] e_rdy, e_rv;
      logic e_err;
      do_reset();
      owner = -1; in_cmd = 0; last = 1; gid = 1'b0; wait_c = 0;
      l_wr = 1'b0; l_ad = '0; l_wd = '0; l_ws = '0;
      for (int n = 0; n < 2; n++) begin
         v[n] = 1'b0; wr[n] = 1'b0; ad[n] = '0; wd[n] = '0; ws[n] = '0; acc[n] = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            if (!v[n] || acc[n]) begin
               v[n] = ($urandom_range(0, 2) != 0); wr[n] = $urandom_range(0, 1);
               ad[n] = $urandom; wd[n] = $urandom; ws[n] = SW'($urandom); acc[n] = 0;
            end
         end
         m0_if.cmd_valid = v[0]; m0_if.cmd_write = wr[0]; m0_if.cmd_addr = ad[0];
         m0_if.cmd_wdata = wd[0]; m0_if.cmd_wstrb = ws[0];
         m1_if.cmd_valid = v[1]; m1_if.cmd_write = wr[1]; m1_if.cmd_addr = ad[1];
         m1_if.cmd_wdata = wd[1]; m1_if.cmd_wstrb = ws[1];
         s_if.cmd_ready = $urandom_range(0, 1);
         s_if.rsp_valid = ($urandom_range(0, 2) == 0);
         s_if.rsp_rdata = $urandom; s_if.rsp_error = $urandom_range(0, 1);
         #1;
         win = -1; fire = 0; tmo = 0;
         if (owner < 0) begin
            if (v[0] && v[1]) win = last ? 0 : 1;
            else if (v[0]) win = 0;
            else if (v[1]) win = 1;
         end else if (in_cmd) begin
            if (s_if.cmd_ready && s_if.rsp_valid) fire = 1;
         end else if (s_if.rsp_valid) fire = 1;
`ifdef ARB_TIMEOUT_EN
         else if (wait_c == int'(TMO) - 1) tmo = 1;
`endif
         e_rdy = '0; e_rv = '0;
         if (win >= 0) e_rdy[win] = 1'b1;
         if (fire || tmo) e_rv[owner] = 1'b1;
         e_data = fire ? s_if.rsp_rdata : '0;
         e_err  = fire ? s_if.rsp_error : 1'b1;
         n_chk++;
         if ({m1_if.cmd_ready, m0_if.cmd_ready} !== e_rdy) begin
            n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", cyc,
                               {m1_if.cmd_ready, m0_if.cmd_ready}, e_rdy);
         end
         n_chk++;
         if ({m1_if.rsp_valid, m0_if.rsp_valid} !== e_rv) begin
            n_fail++; $display("FAIL rand_rsp_valid c%0d: got %b want %b", cyc,
                               {m1_if.rsp_valid, m0_if.rsp_valid}, e_rv);
         end
         n_chk++;
         if ({m0_if.rsp_rdata, m0_if.rsp_error} !== (e_rv[0] ? {e_data, e_err} : 33'h0)) begin
            n_fail++; $display("FAIL rand_m0_data c%0d: got %h/%b want %h/%b", cyc,
                               m0_if.rsp_rdata, m0_if.rsp_error, e_rv[0] ? e_data : 32'h0,
                               e_rv[0] & e_err);
         end
         n_chk++;
         if ({m1_if.rsp_rdata, m1_if.rsp_error} !== (e_rv[1] ? {e_data, e_err} : 33'h0)) begin
            n_fail++; $display("FAIL rand_m1_data c%0d: got %h/%b want %h/%b", cyc,
                               m1_if.rsp_rdata, m1_if.rsp_error, e_rv[1] ? e_data : 32'h0,
                               e_rv[1] & e_err);
         end
         n_chk++;
         if ({s_if.cmd_valid, busy, grant_id} !== {owner >= 0 && in_cmd, owner >= 0, gid}) begin
            n_fail++; $display("FAIL rand_status c%0d: got %b want %b", cyc,
                               {s_if.cmd_valid, busy, grant_id},
                               {owner >= 0 && in_cmd, owner >= 0, gid});
         end
         if (owner >= 0 && in_cmd) begin
            n_chk++;
            if ({s_if.cmd_write, s_if.cmd_addr, s_if.cmd_wdata, s_if.cmd_wstrb} !==
                {l_wr, l_ad, l_wd, l_ws}) begin
               n_fail++; $display("FAIL rand_payload c%0d: got %b %h %h %h want %b %h %h %h",
                                  cyc, s_if.cmd_write, s_if.cmd_addr, s_if.cmd_wdata,
                                  s_if.cmd_wstrb, l_wr, l_ad, l_wd, l_ws);
            end
         end
         if (win >= 0) begin
            owner = win; in_cmd = 1; gid = win[0]; acc[win] = 1; wait_c = 0;
            l_wr = wr[win]; l_ad = ad[win]; l_wd = wd[win]; l_ws = ws[win];
         end else if (fire || tmo) begin
            last = gid; owner = -1; in_cmd = 0;
         end else if (owner >= 0 && in_cmd && s_if.cmd_ready) begin
            in_cmd = 0; wait_c = 0;
         end else if (owner >= 0 && !in_cmd) begin
            wait_c++;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_cmd_stall();
      test_rsp_with_cmd();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
